// File: rtl/par_to_ser_tx_if.sv
// Word-side handshake between a parallel producer and par_to_ser_tx.
interface par_to_ser_tx_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/par_to_ser_tx.sv
// Parallel-to-serial transmitter: accepts a word on valid/ready and shifts it out one bit per clk.
// Optional trailing even-parity bit when PAR_TO_SER_PARITY_EN is defined.
module par_to_ser_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int GAP       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  par_to_ser_tx_if.slave       up,
  output logic                 serial_o,
  output logic                 serial_vld_o,
  output logic                 sof_o,
  output logic                 eof_o,
  output logic                 busy_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
`ifndef PAR_TO_SER_PARITY_EN
  localparam logic [CNT_W-1:0] PEN_BIT  = CNT_W'(WIDTH - 2);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
`ifdef PAR_TO_SER_PARITY_EN
    S_PARITY,
`endif
    S_GAP
  } state_e;

  // Every output is a flop; out_q is what the pins show this cycle.
  typedef struct packed {
    logic ready;
    logic serial;
    logic vld;
    logic sof;
    logic eof;
    logic busy;
  } out_t;

  localparam out_t OUT_RESET = '{ready: 1'b1, serial: 1'b0, vld: 1'b0,
                                 sof: 1'b0, eof: 1'b0, busy: 1'b0};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  out_t              out_q, out_d;
`ifdef PAR_TO_SER_PARITY_EN
  logic              par_q, par_d;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shreg_d   = shreg_q;
    out_d     = '0;
`ifdef PAR_TO_SER_PARITY_EN
    par_d     = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        out_d.ready = 1'b1;
        if (up.valid_i && out_q.ready) begin
          state_d      = S_SHIFT;
          bit_cnt_d    = '0;
          shreg_d      = up.data_i;
`ifdef PAR_TO_SER_PARITY_EN
          par_d        = ^up.data_i;
`endif
          out_d.ready  = 1'b0;
          out_d.serial = (MSB_FIRST != 0) ? up.data_i[WIDTH-1] : up.data_i[0];
          out_d.vld    = 1'b1;
          out_d.sof    = 1'b1;
          out_d.busy   = 1'b1;
        end
      end

      S_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
`ifdef PAR_TO_SER_PARITY_EN
          state_d      = S_PARITY;
          out_d.serial = par_q;
          out_d.vld    = 1'b1;
          out_d.eof    = 1'b1;
          out_d.busy   = 1'b1;
`else
          if (GAP > 0) begin
            state_d    = S_GAP;
            gap_cnt_d  = '0;
            out_d.busy = 1'b1;
          end else begin
            state_d     = S_IDLE;
            out_d.ready = 1'b1;
          end
`endif
        end else begin
          // shreg_q holds the bit on the pins in its edge position; the next bit sits beside it.
          bit_cnt_d    = bit_cnt_q + CNT_W'(1);
          shreg_d      = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
          out_d.serial = (MSB_FIRST != 0) ? shreg_q[WIDTH-2] : shreg_q[1];
          out_d.vld    = 1'b1;
          out_d.busy   = 1'b1;
`ifndef PAR_TO_SER_PARITY_EN
          out_d.eof    = (bit_cnt_q == PEN_BIT);
`endif
        end
      end

`ifdef PAR_TO_SER_PARITY_EN
      S_PARITY: begin
        if (GAP > 0) begin
          state_d    = S_GAP;
          gap_cnt_d  = '0;
          out_d.busy = 1'b1;
        end else begin
          state_d     = S_IDLE;
          out_d.ready = 1'b1;
        end
      end
`endif

      S_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d     = S_IDLE;
          out_d.ready = 1'b1;
        end else begin
          gap_cnt_d  = gap_cnt_q + GAP_W'(1);
          out_d.busy = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_d.ready = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      out_q     <= OUT_RESET;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      out_q     <= out_d;
    end
  end

  // NOTE: the datapath register is left unreset; it is always reloaded on accept before it is read.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef PAR_TO_SER_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign up.ready_o    = out_q.ready;
  assign serial_o      = out_q.serial;
  assign serial_vld_o  = out_q.vld;
  assign sof_o         = out_q.sof;
  assign eof_o         = out_q.eof;
  assign busy_o        = out_q.busy;

endmodule

// File: tb/tb_par_to_ser_tx.sv
// Directed bench for par_to_ser_tx: three instances (LSB-first GAP=2, MSB-first GAP=2, LSB-first GAP=0).
module tb_par_to_ser_tx;

`ifdef PAR_TO_SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  par_to_ser_tx_if #(.WIDTH(8)) if_lsb ();
  par_to_ser_tx_if #(.WIDTH(8)) if_msb ();
  par_to_ser_tx_if #(.WIDTH(8)) if_b2b ();

  logic s_lsb, v_lsb, sf_lsb, ef_lsb, b_lsb;
  logic s_msb, v_msb, sf_msb, ef_msb, b_msb;
  logic s_b2b, v_b2b, sf_b2b, ef_b2b, b_b2b;

  par_to_ser_tx #(.WIDTH(8), .MSB_FIRST(0), .GAP(2)) u_lsb (
    .clk(clk), .reset(reset), .up(if_lsb),
    .serial_o(s_lsb), .serial_vld_o(v_lsb), .sof_o(sf_lsb), .eof_o(ef_lsb), .busy_o(b_lsb));

  par_to_ser_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP(2)) u_msb (
    .clk(clk), .reset(reset), .up(if_msb),
    .serial_o(s_msb), .serial_vld_o(v_msb), .sof_o(sf_msb), .eof_o(ef_msb), .busy_o(b_msb));

  par_to_ser_tx #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) u_b2b (
    .clk(clk), .reset(reset), .up(if_b2b),
    .serial_o(s_b2b), .serial_vld_o(v_b2b), .sof_o(sf_b2b), .eof_o(ef_b2b), .busy_o(b_b2b));

  // Observed outputs packed as {ready, serial, vld, sof, eof, busy}.
  function automatic logic [5:0] obs(input int d);
    case (d)
      0:       return {if_lsb.ready_o, s_lsb, v_lsb, sf_lsb, ef_lsb, b_lsb};
      1:       return {if_msb.ready_o, s_msb, v_msb, sf_msb, ef_msb, b_msb};
      default: return {if_b2b.ready_o, s_b2b, v_b2b, sf_b2b, ef_b2b, b_b2b};
    endcase
  endfunction

  task automatic set_in(input int d, input logic [7:0] data, input logic valid);
    case (d)
      0:       begin if_lsb.data_i = data; if_lsb.valid_i = valid; end
      1:       begin if_msb.data_i = data; if_msb.valid_i = valid; end
      default: begin if_b2b.data_i = data; if_b2b.valid_i = valid; end
    endcase
  endtask

  // Sends one word to an idle instance and checks every frame, gap and return-to-idle cycle.
  // seq[k] is the hand-computed bit expected on serial_o in the k-th frame cycle.
  task automatic tx_frame(input int d, input logic [7:0] word, input logic [8:0] seq,
                          input int gap, input string name);
    logic [5:0] exp;
    @(negedge clk);
    set_in(d, word, 1'b1);
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      if (k > 0) @(negedge clk);
      exp = {1'b0, seq[k], 1'b1, (k == 0), (k == NB - 1), 1'b1};
      checks++;
      if (obs(d) !== exp) begin
        errors++;
        $display("FAIL %s bit%0d: got %b expected %b", name, k, obs(d), exp);
      end
      if (k == 0) set_in(d, ~word, 1'b0);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      checks++;
      if (obs(d) !== 6'b000001) begin
        errors++;
        $display("FAIL %s gap%0d: got %b expected %b", name, g, obs(d), 6'b000001);
      end
    end
    @(negedge clk);
    checks++;
    if (obs(d) !== 6'b100000) begin
      errors++;
      $display("FAIL %s idle: got %b expected %b", name, obs(d), 6'b100000);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) set_in(d, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs(d) !== 6'b100000) begin
          errors++;
          $display("FAIL reset_idle dut%0d cyc%0d: got %b expected %b", d, i, obs(d), 6'b100000);
        end
      end
    end
  endtask

  task automatic test_lsb_first();
    tx_frame(0, 8'hA5, {1'b0, 8'hA5}, 2, "lsb_a5");
  endtask

  task automatic test_msb_first();
    tx_frame(1, 8'h07, {1'b1, 8'hE0}, 2, "msb_07");
    tx_frame(1, 8'hA5, {1'b0, 8'hA5}, 2, "msb_a5");
  endtask

  task automatic test_back_to_back();
    logic [8:0] seq1 = {1'b1, 8'h01};
    logic [8:0] seq2 = {1'b1, 8'h80};
    logic [5:0] exp;
    int t0, t1;
    @(negedge clk);
    set_in(2, 8'h01, 1'b1);
    @(negedge clk);
    t0 = cyc;
    set_in(2, 8'h80, 1'b1);
    for (int k = 0; k < NB; k++) begin
      if (k > 0) @(negedge clk);
      exp = {1'b0, seq1[k], 1'b1, (k == 0), (k == NB - 1), 1'b1};
      checks++;
      if (obs(2) !== exp) begin
        errors++;
        $display("FAIL b2b_first bit%0d: got %b expected %b", k, obs(2), exp);
      end
    end
    @(negedge clk);
    checks++;
    if (obs(2) !== 6'b100000) begin
      errors++;
      $display("FAIL b2b_accept_cycle: got %b expected %b", obs(2), 6'b100000);
    end
    @(negedge clk);
    t1 = cyc;
    set_in(2, 8'h00, 1'b0);
    checks++;
    if (t1 - t0 !== NB + 1) begin
      errors++;
      $display("FAIL b2b_sof_spacing: got %0d expected %0d", t1 - t0, NB + 1);
    end
    for (int k = 0; k < NB; k++) begin
      if (k > 0) @(negedge clk);
      exp = {1'b0, seq2[k], 1'b1, (k == 0), (k == NB - 1), 1'b1};
      checks++;
      if (obs(2) !== exp) begin
        errors++;
        $display("FAIL b2b_second bit%0d: got %b expected %b", k, obs(2), exp);
      end
    end
    @(negedge clk);
    checks++;
    if (obs(2) !== 6'b100000) begin
      errors++;
      $display("FAIL b2b_idle: got %b expected %b", obs(2), 6'b100000);
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    set_in(0, 8'hFF, 1'b1);
    @(negedge clk);
    set_in(0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (obs(0) !== 6'b011001) begin
      errors++;
      $display("FAIL rst_mid_bit3: got %b expected %b", obs(0), 6'b011001);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (obs(0) !== 6'b100000) begin
      errors++;
      $display("FAIL rst_mid_abort: got %b expected %b", obs(0), 6'b100000);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs(0) !== 6'b100000) begin
        errors++;
        $display("FAIL rst_mid_quiet cyc%0d: got %b expected %b", i, obs(0), 6'b100000);
      end
    end
    tx_frame(0, 8'h3C, {1'b0, 8'h3C}, 2, "rst_recover_3c");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
